// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request arbiter: widths, counts and FSM states.
package spi_pkg;

    localparam int NUM_SLAVES = 4;
    localparam int SEL_W      = $clog2(NUM_SLAVES);
    localparam int NUM_REQ    = 4;
    localparam int REQ_IDX_W  = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Index to one-hot requester vector
    function automatic logic [NUM_REQ-1:0] idx2oh(input logic [REQ_IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: searches from last_grant+1 upward (mod NUM_REQ)
// and returns the first valid requester as one-hot plus index.
module spi_rr_picker
    import spi_pkg::*;
(
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [REQ_IDX_W-1:0] i_last_grant,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [REQ_IDX_W-1:0] o_grant_idx
);

    logic                 w_found;
    logic [REQ_IDX_W-1:0] w_cand;

    // Walk the rotated priority order; index arithmetic wraps naturally
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = i_last_grant + REQ_IDX_W'(k);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Arbitrates four requesters onto one SPI master: accept, start pulse, wait for
// transfer end, one-cycle response. Optional WAIT timeout under SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int bits_num       = 8,
    parameter int timeout_cycles = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
    input  logic [NUM_REQ*bits_num-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [bits_num-1:0]         rsp_data,
    output logic                        rsp_err,
    output logic                        spi_tx_start,
    output logic [SEL_W-1:0]            spi_sel,
    output logic [bits_num-1:0]         spi_data_out,
    input  logic                        spi_tx_end,
    input  logic [bits_num-1:0]         spi_data_in,
    output logic                        busy
);

    arb_state_e           r_state, w_next_state;
    logic [REQ_IDX_W-1:0] r_last_grant, r_grant_idx;
    logic [SEL_W-1:0]     r_spi_sel;
    logic [bits_num-1:0]  r_spi_data_out, r_rsp_data;
    logic [NUM_REQ-1:0]   w_grant;
    logic [REQ_IDX_W-1:0] w_grant_idx;
    logic                 w_accept, w_done, w_timeout;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_cycles + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_err;
`endif

    spi_rr_picker u_picker (
        .i_req_valid (req_valid),
        .i_last_grant(r_last_grant),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Next-state decode; accept/done/timeout are single-cycle events
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: w_next_state = ST_WAIT;
            ST_WAIT: begin
                // A transfer end on the final WAIT cycle beats the timeout
                if (spi_tx_end) begin
                    w_done       = 1'b1;
                    w_next_state = ST_RESP;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(timeout_cycles - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_RESP;
                end
`endif
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Grant bookkeeping, SPI command latch and response capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant   <= REQ_IDX_W'(NUM_REQ - 1);
            r_grant_idx    <= '0;
            r_spi_sel      <= '0;
            r_spi_data_out <= '0;
            r_rsp_data     <= '0;
        end else begin
            if (w_accept) begin
                r_grant_idx    <= w_grant_idx;
                r_spi_sel      <= req_sel[w_grant_idx*SEL_W +: SEL_W];
                r_spi_data_out <= req_data[w_grant_idx*bits_num +: bits_num];
            end
            if (w_done)         r_rsp_data <= spi_data_in;
            else if (w_timeout) r_rsp_data <= '0;
            if (r_state == ST_RESP) r_last_grant <= r_grant_idx;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // WAIT cycle counter (cleared in START) and sticky-until-next-capture error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == ST_START)     r_cnt <= '0;
            else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
            if (w_done)         r_rsp_err <= 1'b0;
            else if (w_timeout) r_rsp_err <= 1'b1;
        end
    end
    assign rsp_err = r_rsp_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (timeout_cycles != 0);
    assign rsp_err      = 1'b0;
`endif

    assign req_ready    = w_accept ? w_grant : '0;
    assign rsp_valid    = (r_state == ST_RESP) ? idx2oh(r_grant_idx) : '0;
    assign spi_tx_start = (r_state == ST_START);
    assign busy         = (r_state != ST_IDLE);
    assign spi_sel      = r_spi_sel;
    assign spi_data_out = r_spi_data_out;
    assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: directed table, hand sequences and random traffic
// against a transaction-level round-robin model.
module tb_spi_req_arbiter;

    localparam int BW  = 8;
    localparam int TMO = 16;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk, reset;
    logic [3:0]    req_valid, req_ready, rsp_valid;
    logic [7:0]    req_sel;
    logic [4*BW-1:0] req_data;
    logic [BW-1:0] rsp_data, spi_data_out, spi_data_in;
    logic          rsp_err, spi_tx_start, spi_tx_end, busy;
    logic [1:0]    spi_sel;

    spi_req_arbiter #(.bits_num(BW), .timeout_cycles(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .spi_tx_start(spi_tx_start), .spi_sel(spi_sel),
        .spi_data_out(spi_data_out), .spi_tx_end(spi_tx_end),
        .spi_data_in(spi_data_in), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    int         m_last;          // model: last granted requester
    logic [7:0] m_rsp;           // model: last captured response word

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // First valid requester scanning from last+1, wrapping mod 4
    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One full transaction from an IDLE negedge; delay 0 means no tx_end.
    // bg is held on req_valid during WAIT and dropped before RESP.
    task automatic run_txn(input logic [3:0] v, input logic [7:0] sels, input logic [31:0] datas,
                           input logic [7:0] rx, input int delay, input int exp_g, input logic [3:0] bg);
        logic [3:0] exp_oh;
        logic [1:0] exp_sel;
        logic [7:0] exp_dat;
        bit         tmo, quiet, stable;
        int         n_wait;
        exp_oh  = 4'(1 << exp_g);
        exp_sel = sels[exp_g*2 +: 2];
        exp_dat = datas[exp_g*8 +: 8];
        tmo     = TO_EN && (delay == 0 || delay > TMO);
        n_wait  = tmo ? TMO : delay;
        req_valid = v; req_sel = sels; req_data = datas;
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_oh));
        @(negedge clk);
        req_valid = '0;
        chk("tx_start", 64'({spi_tx_start, busy}), 64'(2'b11));
        chk("spi_sel", 64'(spi_sel), 64'(exp_sel));
        chk("spi_data_out", 64'(spi_data_out), 64'(exp_dat));
        quiet = 1; stable = 1;
        for (int i = 1; i <= n_wait; i++) begin
            @(negedge clk);
            req_valid   = (i == n_wait) ? 4'b0 : bg;
            spi_tx_end  = !tmo && (i == n_wait);
            spi_data_in = (i == n_wait) ? rx : 8'($urandom);
            #1;
            if (spi_tx_start || rsp_valid != 0 || req_ready != 0 || !busy) quiet = 0;
            if (spi_sel != exp_sel || spi_data_out != exp_dat) stable = 0;
        end
        @(negedge clk);
        spi_tx_end = 1'b0;
        m_rsp = tmo ? 8'h00 : rx;
        chk("wait_quiet", 64'(quiet), 64'(1));
        chk("cmd_stable", 64'(stable), 64'(1));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_oh));
        chk("rsp_err", 64'(rsp_err), 64'(tmo));
        chk("rsp_data", 64'(rsp_data), 64'(m_rsp));
        m_last = exp_g;
        @(negedge clk);
        chk("rsp_one_cycle", 64'({busy, rsp_valid, req_ready}), 64'(0));
        @(negedge clk);
        chk("dropped_not_served", 64'({busy, rsp_data}), 64'({1'b0, m_rsp}));
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [7:0]  sel;
        logic [31:0] data;
        logic [7:0]  rx;
        int          delay;
        int          g;
    } vec_t;

    vec_t tbl[10];
    bit   q;

    initial begin
        tbl[0] = '{4'b1111, 8'hE4, 32'h44332211, 8'h10, 1,  0};
        tbl[1] = '{4'b1111, 8'hE4, 32'h44332211, 8'h21, 2,  1};
        tbl[2] = '{4'b1111, 8'h1B, 32'hDDCCBBAA, 8'h32, 3,  2};
        tbl[3] = '{4'b1111, 8'h1B, 32'hDDCCBBAA, 8'h43, 16, 3};
        tbl[4] = '{4'b0010, 8'h08, 32'h00005500, 8'h54, 4,  1};
        tbl[5] = '{4'b1001, 8'hC1, 32'h9F0000E7, 8'h65, 5,  3};
        tbl[6] = '{4'b1001, 8'hC1, 32'h9F0000E7, 8'h76, 6,  0};
        tbl[7] = '{4'b0100, 8'h20, 32'h00770000, 8'h87, 7,  2};
        tbl[8] = '{4'b0101, 8'h13, 32'h00660099, 8'h98, 9,  0};
        tbl[9] = '{4'b0001, 8'h00, 32'h000000AB, 8'hC8, 18, 0};

        reset = 1'b0; req_valid = '0; req_sel = '0; req_data = '0;
        spi_tx_end = 1'b0; spi_data_in = '0;
        m_last = 3; m_rsp = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_err, spi_tx_start,
                                  spi_sel, spi_data_out, busy}), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rx, tbl[i].delay, tbl[i].g, 4'b0);

        // Spurious tx_end in IDLE must not produce a response or touch rsp_data
        spi_tx_end = 1'b1; spi_data_in = 8'h5A;
        @(negedge clk);
        spi_tx_end = 1'b0;
        chk("spurious_idle", 64'({busy, rsp_valid, rsp_data}), 64'({5'b0, m_rsp}));
        run_txn(4'b0100, 8'h20, 32'h00E10000, 8'h3C, 7, pick(4'b0100, m_last), 4'b1010);

`ifdef SPI_ARB_TIMEOUT_EN
        run_txn(4'b0010, 8'h04, 32'h00001200, 8'hEE, 0, pick(4'b0010, m_last), 4'b0);
        run_txn(4'b0010, 8'h04, 32'h00003400, 8'h77, TMO, pick(4'b0010, m_last), 4'b0);
`endif

        // Reset five cycles into WAIT abandons the transaction
        req_valid = 4'b1000; req_sel = 8'hC0; req_data = 32'h5A000000;
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_mid_wait", 64'({req_ready, rsp_valid, rsp_data, rsp_err, spi_tx_start,
                                   spi_sel, spi_data_out, busy}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        m_last = 3; m_rsp = 8'h00;
        spi_tx_end = 1'b1; spi_data_in = 8'h99;
        q = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spi_tx_end = 1'b0;
            if (rsp_valid != 0 || busy) q = 0;
        end
        chk("no_rsp_after_reset", 64'(q), 64'(1));
        run_txn(4'b1111, 8'hE4, 32'h44332211, 8'hA5, 3, 0, 4'b0);

        // Random traffic against the model
        for (int n = 0; n < 40; n++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            if (v == 0) begin
                spi_tx_end = 1'($urandom); spi_data_in = 8'($urandom);
                #1;
                chk("rand_idle", 64'({busy, req_ready, rsp_valid}), 64'(0));
                @(negedge clk);
                spi_tx_end = 1'b0;
            end else begin
                run_txn(v, 8'($urandom), $urandom, 8'($urandom), $urandom_range(1, 12),
                        pick(v, m_last), 4'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
- REQ-001: Parameter bits_num, 8: SPI word width; shall match the SPI top instance.
- REQ-002: Parameter timeout_cycles, 256: WAIT-state cycles before abort; only used with SPI_ARB_TIMEOUT_EN.
- REQ-003: clk  in  1  single clock; all logic on the rising edge.
- REQ-004: reset  in  1  asynchronous, active-low reset.
- REQ-005: req_valid  in  4  per-requester transaction request.
- REQ-006: req_sel  in  8  2-bit target slave per requester; requester i uses [2i+1:2i].
- REQ-007: req_data  in  4*bits_num  per-requester TX word; requester i uses slice i.
- REQ-008: req_ready  out  4  one-hot accept strobe.
- REQ-009: rsp_valid  out  4  one-hot, one-cycle completion strobe.
- REQ-010: rsp_data  out  bits_num  received word; qualified by rsp_valid.
- REQ-011: rsp_err  out  1  timeout flag; qualified by rsp_valid.
- REQ-012: spi_tx_start  out  1  one-cycle start pulse to the SPI top.
- REQ-013: spi_sel  out  2  slave select to the SPI top.
- REQ-014: spi_data_out  out  bits_num  word to the master_data_in port.
- REQ-015: spi_tx_end  in  1  transfer-complete strobe from the SPI top.
- REQ-016: spi_data_in  in  bits_num  word from the master_data_out port.
- REQ-017: busy  out  1  high in any state other than IDLE.

Function
- REQ-018: The FSM shall have exactly the states IDLE, START, WAIT and RESP.
- REQ-019: IDLE with any req_valid: pick winner g round-robin, starting at (last_grant+1) mod 4; assert req_ready[g] combinationally that cycle; latch req_sel/req_data of g into spi_sel/spi_data_out; go START.
- REQ-020: START: spi_tx_start=1 for exactly one cycle, then go WAIT.
- REQ-021: spi_sel and spi_data_out shall stay stable from START until leaving WAIT.
- REQ-022: WAIT: on spi_tx_end=1, capture spi_data_in into rsp_data, clear rsp_err, go RESP.
- REQ-023: RESP: rsp_valid[g]=1 for one cycle; last_grant<=g; go IDLE.
- REQ-024: Latency: accept at cycle T, spi_tx_start at T+1, rsp_valid one cycle after the cycle with spi_tx_end; earliest next accept is the cycle after RESP.
- REQ-025: spi_tx_end in IDLE, START or RESP shall be ignored.
- REQ-026: A requester dropping req_valid before its req_ready shall not be served; no state change.
- REQ-027: rsp_data shall hold its value until the next capture.

Reset
- REQ-028: reset low shall immediately force:
  - state IDLE, last_grant=3 (requester 0 first);
  - spi_tx_start, req_ready, rsp_valid, rsp_err, busy = 0;
  - spi_sel=0, spi_data_out=0, rsp_data=0.
- REQ-029: Reset mid-transaction shall abandon it; no rsp_valid shall be issued for it.

Configuration
- REQ-030: With SPI_ARB_TIMEOUT_EN defined: a counter shall clear on entering WAIT and count WAIT cycles; if the timeout_cycles-th WAIT cycle passes without spi_tx_end, go RESP with rsp_err=1 and rsp_data=0.
- REQ-031: With SPI_ARB_TIMEOUT_EN defined: spi_tx_end on the final WAIT cycle shall win, giving rsp_err=0 and normal data.
- REQ-032: Without SPI_ARB_TIMEOUT_EN: WAIT shall hold indefinitely, rsp_err shall be tied 0 and no counter shall exist.

Structure
- REQ-033: Shared package spi_pkg shall hold SEL_W=2, NUM_SLAVES=4 and the FSM state enum.
- REQ-034: Sub-module spi_rr_picker shall be combinational: inputs req_valid and last_grant; outputs one-hot grant plus index.

Verification
- REQ-035: Single request: req 0, sel 00, data 8'hAB; model spi_tx_end 18 cycles after start with 8'hC8 -> spi_sel=00, spi_data_out=8'hAB, rsp_valid[0] one cycle after tx_end, rsp_data=8'hC8, rsp_err=0.
- REQ-036: Round-robin: all four valid after reset -> grants 0,1,2,3 in order; then reqs 0 and 3 after grant 1 -> grant 3 before 0.
- REQ-037: Spurious end: spi_tx_end pulsed in IDLE, then a request to sel 10 -> no rsp_valid until a tx_end during WAIT.
- REQ-038: Timeout (macro on, timeout_cycles=16), no tx_end -> rsp_valid 17 cycles after spi_tx_start, rsp_err=1, rsp_data=0; the same run with tx_end on WAIT cycle 16 -> rsp_err=0.
- REQ-039: Reset asserted 5 cycles into WAIT -> all outputs at reset values, no rsp_valid; next request goes to requester 0 first.
